xnor_pattern_detector: RTL and testbench
========================================

XNOR_PATTERN_DETECTOR -- requirements
Module: xnor_pattern_detector

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set window/pattern width in bits (legal range 1..32).
REQ-002 Parameter COUNT_W, default 8, SHALL set match_count width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  qualifies din; when low, no shift and no compare.
REQ-007 pattern  input  WIDTH  reference word; bit i is compared to window bit i.
REQ-008 mask  input  WIDTH  compare enable per bit; 0 = don't care.
REQ-009 mode  input  1  0 = exact match, 1 = threshold match.
REQ-010 threshold  input  clog2(WIDTH+1)  minimum agreeing bits in mode 1.
REQ-011 overlap  input  1  1 = overlapping detection, 0 = window refills after each match.
REQ-012 match  output  1  one-cycle pulse per detected match.
REQ-013 agree_cnt  output  clog2(WIDTH+1)  masked XNOR agreement count of the latest window.
REQ-014 match_count  output  COUNT_W  saturating total of matches.

Function
REQ-015 On each edge with din_valid=1, window SHALL shift left by one, din entering bit 0 (bit WIDTH-1 = oldest).
REQ-016 FSM SHALL have two states: FILL (fewer than WIDTH valid bits since reset/refill) and RUN.
REQ-017 Fill counter SHALL increment per valid bit in FILL; FILL->RUN on the valid bit that makes WIDTH bits.
REQ-018 agree_cnt SHALL equal popcount(mask & ~(window ^ pattern)) of the post-shift window, registered on the same valid edge, held otherwise.
REQ-019 Mode 0: match condition SHALL be agree_cnt == popcount(mask); mode 1: agree_cnt >= threshold.
REQ-020 match SHALL assert for exactly one cycle, registered at the valid edge that shifts in the completing bit, only when the post-shift window is full; din_valid=0 cycles SHALL drive match=0.
REQ-021 mask == 0 SHALL suppress match in both modes.
REQ-022 pattern, mask, mode, threshold changes SHALL affect only compares at later valid edges.
REQ-023 On match with overlap=0, FSM SHALL return to FILL with fill counter 0; window contents retained but ignored until refilled.
REQ-024 On match with overlap=1, FSM SHALL stay in RUN.
REQ-025 match_count SHALL increment by 1 per match and saturate at 2^COUNT_W-1.
REQ-026 WIDTH=1 SHALL work: every valid bit completes a window.

Reset
REQ-027 rst=1 at an edge SHALL clear window, fill counter, agree_cnt, match, match_count to 0 and force FILL, overriding din_valid.
REQ-028 Reset mid-stream SHALL discard partial windows; a fresh WIDTH valid bits SHALL be needed before any match.

Structure
REQ-029 Package xnor_det_pkg SHALL hold FSM state encoding (FILL=0, RUN=1) and default WIDTH/COUNT_W constants.
REQ-030 Sub-module xnor_popcount (combinational masked XNOR + popcount, parametrised by WIDTH) SHALL compute agreement.

Verification (WIDTH=4, COUNT_W=2 unless stated; bits listed oldest-first)
REQ-031 rst high 2 cycles with din_valid=1 -> match=0, agree_cnt=0, match_count=0, state FILL.
REQ-032 pattern=1011, mask=1111, mode=0, bits 1,0,1,1 -> match pulse after 4th bit, agree_cnt=4, match_count=1; gaps of din_valid=0 between bits give the same result.
REQ-033 pattern=1010, bits 1,0,1,0,1,0: overlap=1 -> matches after bits 4 and 6 (count=2); overlap=0 -> match after bit 4 only (count=1).
REQ-034 mode=1, pattern=1111, bits 1,1,0,1 -> agree_cnt=3; threshold=3 -> match=1; threshold=4 -> match=0; mask=0000 -> match=0.
REQ-035 pattern=0000, overlap=1, seven 0 bits -> 4 matches, match_count saturates at 3.
REQ-036 Three valid bits, rst pulse, then 1,0,1,1 with pattern=1011 -> no match before 4th post-reset bit, match on it.

Source files
------------

// File: rtl/xnor_det_pkg.sv
// Shared types and defaults for the XNOR pattern detector.
// Holds the FSM state encoding and the default widths.
package xnor_det_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_COUNT_W = 8;

endpackage

// File: rtl/xnor_det_popcount.sv
// Combinational masked XNOR agreement counter.
// Counts bit positions where mask is set and window equals pattern.
module xnor_popcount #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] window_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [CW-1:0]    count_o
);

    // Sum the per-bit agreement flags.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o
                    + CW'(mask_i[i] & ~(window_i[i] ^ pattern_i[i]));
        end
    end

endmodule

// File: rtl/xnor_pattern_detector.sv
// Serial masked pattern detector with exact/threshold modes.
// Window fills after reset or after a non-overlapping match.
module xnor_pattern_detector
    import xnor_det_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int COUNT_W = DEF_COUNT_W,
    localparam int CW      = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic [WIDTH-1:0]   pattern,
    input  logic [WIDTH-1:0]   mask,
    input  logic               mode,
    input  logic [CW-1:0]      threshold,
    input  logic               overlap,
    output logic               match,
    output logic [CW-1:0]      agree_cnt,
    output logic [COUNT_W-1:0] match_count
);

    localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH - 1);

    state_e             state_q;
    logic [CW-1:0]      fill_q;
    logic [WIDTH-1:0]   window_q;
    logic [WIDTH-1:0]   window_d;
    logic [CW-1:0]      agree_q;
    logic [CW-1:0]      agree_d;
    logic               match_q;
    logic [COUNT_W-1:0] count_q;
    logic               full_d;
    logic               exact_d;
    logic               hit_d;

    assign window_d = (window_q << 1) | WIDTH'(din);

    xnor_popcount #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_pop (
        .window_i  (window_d),
        .pattern_i (pattern),
        .mask_i    (mask),
        .count_o   (agree_d)
    );

    // Window counts as full once this bit completes WIDTH valid bits.
    assign full_d  = (state_q == RUN) || (fill_q == FILL_LAST);
    // Exact match: no enabled bit disagrees.
    assign exact_d = ((mask & (window_d ^ pattern)) == '0);
    assign hit_d   = full_d && (mask != '0)
                   && (mode ? (agree_d >= threshold) : exact_d);

    // Shift, compare, count and sequence the fill/run FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            fill_q   <= '0;
            window_q <= '0;
            agree_q  <= '0;
            match_q  <= 1'b0;
            count_q  <= '0;
        end else if (din_valid) begin
            window_q <= window_d;
            agree_q  <= agree_d;
            match_q  <= hit_d;
            if (hit_d && (count_q != '1)) begin
                count_q <= count_q + COUNT_W'(1);
            end
            unique case (state_q)
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        fill_q  <= '0;
                        state_q <= (hit_d && !overlap) ? FILL : RUN;
                    end else begin
                        fill_q <= fill_q + CW'(1);
                    end
                end
                RUN: begin
                    if (hit_d && !overlap) begin
                        state_q <= FILL;
                        fill_q  <= '0;
                    end
                end
                default: begin
                    state_q <= FILL;
                    fill_q  <= '0;
                end
            endcase
        end else begin
            match_q <= 1'b0;
        end
    end

    assign match       = match_q;
    assign agree_cnt   = agree_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_xnor_pattern_detector.sv
// Bench for xnor_pattern_detector (WIDTH=4, COUNT_W=2).
// Queue-based reference model plus directed literal checks.
module tb_xnor_pattern_detector;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam int KW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [W-1:0]  mask = '1;
    logic          mode = 1'b0;
    logic [CW-1:0] threshold = '0;
    logic          overlap = 1'b0;
    logic          match;
    logic [CW-1:0] agree_cnt;
    logic [KW-1:0] match_count;

    int total  = 0;
    int passed = 0;

    xnor_pattern_detector #(
        .WIDTH   (W),
        .COUNT_W (KW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .pattern     (pattern),
        .mask        (mask),
        .mode        (mode),
        .threshold   (threshold),
        .overlap     (overlap),
        .match       (match),
        .agree_cnt   (agree_cnt),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: history queue of bits, count since (re)fill.
    bit q[$];
    int n_since = 0;
    int e_agree = 0;
    int e_match = 0;
    int e_count = 0;
    bit model_on = 0;

    always @(posedge clk) begin
        int mk;
        int wb;
        bit hit;
        model_on = 1;
        if (rst) begin
            q.delete();
            n_since = 0;
            e_agree = 0;
            e_match = 0;
            e_count = 0;
        end else if (din_valid) begin
            q.push_back(din);
            if (q.size() > W) void'(q.pop_front());
            n_since++;
            e_agree = 0;
            mk = 0;
            for (int i = 0; i < W; i++) begin
                wb = (q.size() > i) ? int'(q[q.size() - 1 - i]) : 0;
                if (mask[i]) begin
                    mk++;
                    if (wb == int'(pattern[i])) e_agree++;
                end
            end
            hit = (n_since >= W) && (mk > 0) &&
                  (mode ? (e_agree >= int'(threshold)) : (e_agree == mk));
            e_match = hit ? 1 : 0;
            if (hit) begin
                if (e_count < (1 << KW) - 1) e_count++;
                if (!overlap) n_since = 0;
            end
        end else begin
            e_match = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_match", int'(match), e_match);
            chk("m_agree", int'(agree_cnt), e_agree);
            chk("m_count", int'(match_count), e_count);
        end
    end

    task automatic send(input bit b);
        @(negedge clk);
        din_valid = 1'b1;
        din = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send4(input logic [3:0] v, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send(v[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        din_valid = 1'b1;
        din = 1'b1;
        rst = 1'b1;
        idle(2);
        chk("rst_match", int'(match), 0);
        chk("rst_agree", int'(agree_cnt), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_state", int'(dut.state_q), 0);
        din_valid = 1'b0;
        rst = 1'b0;

        pattern = 4'b1011; mask = 4'b1111; mode = 0; overlap = 0;
        send(1); send(0); send(1);
        chk("ex_early", int'(match), 0);
        send(1);
        chk("ex_match", int'(match), 1);
        chk("ex_agree", int'(agree_cnt), 4);
        chk("ex_count", int'(match_count), 1);
        idle(1);
        chk("ex_pulse", int'(match), 0);

        do_reset();
        send4(4'b1011, 2);
        chk("gap_count", int'(match_count), 1);
        chk("gap_agree", int'(agree_cnt), 4);

        do_reset();
        pattern = 4'b1010; overlap = 1;
        send4(4'b1010, 0);
        send(1);
        chk("ov_b5", int'(match), 0);
        send(0);
        chk("ov_b6", int'(match), 1);
        chk("ov_count", int'(match_count), 2);

        do_reset();
        overlap = 0;
        send4(4'b1010, 0);
        send(1); send(0);
        chk("nov_b6", int'(match), 0);
        chk("nov_count", int'(match_count), 1);

        do_reset();
        mode = 1; pattern = 4'b1111; overlap = 1; threshold = 3;
        send4(4'b1101, 0);
        chk("th3_agree", int'(agree_cnt), 3);
        chk("th3_match", int'(match), 1);
        do_reset();
        threshold = 4;
        send4(4'b1101, 0);
        chk("th4_match", int'(match), 0);
        do_reset();
        threshold = 3; mask = 4'b0000;
        send4(4'b1101, 0);
        chk("m0_match", int'(match), 0);
        chk("m0_agree", int'(agree_cnt), 0);

        do_reset();
        mode = 0; mask = 4'b1111; pattern = 4'b0000; overlap = 1;
        for (int i = 0; i < 7; i++) send(0);
        chk("sat_match", int'(match), 1);
        chk("sat_count", int'(match_count), 3);

        do_reset();
        pattern = 4'b1011; overlap = 0;
        send(1); send(1); send(1);
        do_reset();
        send(1); send(0); send(1);
        chk("mid_nomatch", int'(match), 0);
        send(1);
        chk("mid_match", int'(match), 1);
        chk("mid_count", int'(match_count), 1);

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
